// File: rtl/rf_write_ctrl.sv
// Register-file write-port arbiter (RW stage over MDU) plus per-register in-flight scoreboard.
// Write port has one-cycle registered latency; the MDU is held off while the RW stage writes; OF stalls on RAW or counter-full.
module rf_write_ctrl #(
    parameter int NREG    = 16,
    parameter int RADDR_W = 4,
    parameter int DATA_W  = 32,
    parameter int CNT_W   = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               issue_valid,
    input  logic               issue_wb,
    input  logic [RADDR_W-1:0] issue_rd,
    input  logic [RADDR_W-1:0] issue_rs1,
    input  logic [RADDR_W-1:0] issue_rs2,
    input  logic               issue_use1,
    input  logic               issue_use2,
    output logic               stall_OF,
    input  logic               wb_valid,
    input  logic [RADDR_W-1:0] wb_rd,
    input  logic [DATA_W-1:0]  wb_data,
    input  logic               mdu_valid,
    input  logic [RADDR_W-1:0] mdu_rd,
    input  logic [DATA_W-1:0]  mdu_data,
    output logic               mdu_ready,
    output logic               rf_we,
    output logic [RADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0]  rf_wdata,
    output logic [NREG-1:0]    busy,
    output logic               err_underflow
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0]   cnt_q [NREG];
    logic [CNT_W-1:0]   cnt_d [NREG];
    logic               rf_we_q, rf_we_d;
    logic [RADDR_W-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0]  rf_wdata_q, rf_wdata_d;
    logic               err_q, err_d;
    logic               inc;
    logic [NREG-1:0]    inc_hit;
    logic [NREG-1:0]    dec_hit;

    assign mdu_ready = ~wb_valid;

    always_comb begin
        stall_OF = issue_valid &
                   ((issue_use1 & (cnt_q[issue_rs1] != '0)) |
                    (issue_use2 & (cnt_q[issue_rs2] != '0)) |
                    (issue_wb   & (cnt_q[issue_rd]  == CNT_MAX)));
        inc = issue_valid & issue_wb & ~stall_OF;
    end

    always_comb begin
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (wb_valid) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = wb_rd;
            rf_wdata_d = wb_data;
        end else if (mdu_valid) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = mdu_rd;
            rf_wdata_d = mdu_data;
        end
    end

    // The decrement is driven by the registered write, so a register reads busy until its write lands.
    always_comb begin
        err_d   = err_q;
        inc_hit = '0;
        dec_hit = '0;
        busy    = '0;
        for (int i = 0; i < NREG; i++) begin
            inc_hit[i] = inc && (issue_rd == RADDR_W'(i));
            dec_hit[i] = rf_we_q && (rf_waddr_q == RADDR_W'(i));
            busy[i]    = (cnt_q[i] != '0);
            cnt_d[i]   = cnt_q[i];
            if (dec_hit[i] && (cnt_q[i] == '0)) begin
                err_d = 1'b1;
            end
            if (inc_hit[i] && !dec_hit[i]) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end else if (dec_hit[i] && !inc_hit[i] && (cnt_q[i] != '0)) begin
                cnt_d[i] = cnt_q[i] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                cnt_q[i] <= '0;
            end
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            err_q      <= 1'b0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            err_q      <= err_d;
        end
    end

    assign rf_we         = rf_we_q;
    assign rf_waddr      = rf_waddr_q;
    assign rf_wdata      = rf_wdata_q;
    assign err_underflow = err_q;

endmodule

// File: tb/tb_rf_write_ctrl.sv
// Directed and randomized bench for rf_write_ctrl against a per-register counter model.
module tb_rf_write_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid, issue_wb, issue_use1, issue_use2;
    logic [3:0]  issue_rd, issue_rs1, issue_rs2;
    logic        stall_OF;
    logic        wb_valid;
    logic [3:0]  wb_rd;
    logic [31:0] wb_data;
    logic        mdu_valid;
    logic [3:0]  mdu_rd;
    logic [31:0] mdu_data;
    logic        mdu_ready;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [15:0] busy;
    logic        err_underflow;

    rf_write_ctrl dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_wb(issue_wb), .issue_rd(issue_rd),
        .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_use1(issue_use1), .issue_use2(issue_use2),
        .stall_OF(stall_OF),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .mdu_valid(mdu_valid), .mdu_rd(mdu_rd), .mdu_data(mdu_data),
        .mdu_ready(mdu_ready),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .busy(busy), .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference state: in-flight count per register and the pending port write.
    int          m_cnt [16];
    bit          m_we;
    int          m_waddr;
    logic [31:0] m_wdata;
    bit          m_err;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit m_stall();
        return issue_valid && ((issue_use1 && m_cnt[issue_rs1] != 0) ||
                               (issue_use2 && m_cnt[issue_rs2] != 0) ||
                               (issue_wb   && m_cnt[issue_rd] == 3));
    endfunction

    function automatic logic [15:0] m_busy();
        logic [15:0] b;
        for (int i = 0; i < 16; i++) b[i] = (m_cnt[i] != 0);
        return b;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 16; i++) m_cnt[i] = 0;
        m_we = 0; m_waddr = 0; m_wdata = '0; m_err = 0;
    endtask

    task automatic idle();
        issue_valid = 0; issue_wb = 0; issue_use1 = 0; issue_use2 = 0;
        issue_rd = 0; issue_rs1 = 0; issue_rs2 = 0;
        wb_valid = 0; wb_rd = 0; wb_data = '0;
        mdu_valid = 0; mdu_rd = 0; mdu_data = '0;
    endtask

    // Called just after a falling edge with inputs applied; checks everything, advances one cycle.
    task automatic step();
        bit inc;
        int inc_rd;
        #1;
        check_eq("stall_OF", stall_OF, m_stall());
        check_eq("mdu_ready", mdu_ready, !wb_valid);
        check_eq("rf_we", rf_we, m_we);
        check_eq("rf_waddr", rf_waddr, m_waddr);
        check_eq("rf_wdata", rf_wdata, m_wdata);
        check_eq("busy", busy, m_busy());
        check_eq("err_underflow", err_underflow, m_err);
        inc    = issue_valid && issue_wb && !m_stall();
        inc_rd = issue_rd;
        @(posedge clk);
        if (m_we && m_cnt[m_waddr] == 0) m_err = 1;
        if (!(inc && m_we && inc_rd == m_waddr)) begin
            if (inc) m_cnt[inc_rd]++;
            if (m_we && m_cnt[m_waddr] > 0) m_cnt[m_waddr]--;
        end
        if (wb_valid) begin
            m_we = 1; m_waddr = wb_rd; m_wdata = wb_data;
        end else if (mdu_valid) begin
            m_we = 1; m_waddr = mdu_rd; m_wdata = mdu_data;
        end else begin
            m_we = 0;
        end
        @(negedge clk);
    endtask

    task automatic do_reset(input string tag);
        rst = 1;
        #1;
        check_eq({tag, "_rf_we"}, rf_we, 0);
        check_eq({tag, "_rf_waddr"}, rf_waddr, 0);
        check_eq({tag, "_rf_wdata"}, rf_wdata, 0);
        check_eq({tag, "_busy"}, busy, 16'h0000);
        check_eq({tag, "_err"}, err_underflow, 0);
        check_eq({tag, "_stall"}, stall_OF, 0);
        check_eq({tag, "_mdu_ready"}, mdu_ready, !wb_valid);
        m_reset();
        @(negedge clk);
        rst = 0;
    endtask

    initial begin
        idle();
        m_reset();
        rst = 0;
        #2;
        do_reset("reset");

        // RAW on r3: the reader stalls until the cycle after the write is presented.
        issue_valid = 1; issue_wb = 1; issue_rd = 3;
        step();
        issue_wb = 0; issue_use1 = 1; issue_rs1 = 3;
        #1; check_eq("raw_stall_c1", stall_OF, 1);
        step();
        step();
        wb_valid = 1; wb_rd = 3; wb_data = 32'hDEAD_BEEF;
        step();
        wb_valid = 0;
        #1;
        check_eq("raw_we", rf_we, 1);
        check_eq("raw_waddr", rf_waddr, 3);
        check_eq("raw_wdata", rf_wdata, 32'hDEAD_BEEF);
        check_eq("raw_stall_during_we", stall_OF, 1);
        step();
        #1;
        check_eq("raw_busy3_clear", busy[3], 0);
        check_eq("raw_stall_drop", stall_OF, 0);
        step();
        idle();

        // RW stage beats the MDU; the MDU write follows one cycle later.
        wb_valid = 1; wb_rd = 5; wb_data = 32'h5555_0005;
        mdu_valid = 1; mdu_rd = 7; mdu_data = 32'h7777_0007;
        #1; check_eq("arb_mdu_ready0", mdu_ready, 0);
        step();
        wb_valid = 0;
        #1;
        check_eq("arb_mdu_ready1", mdu_ready, 1);
        check_eq("arb_first_addr", rf_waddr, 5);
        step();
        mdu_valid = 0;
        #1;
        check_eq("arb_second_we", rf_we, 1);
        check_eq("arb_second_addr", rf_waddr, 7);
        check_eq("arb_second_data", rf_wdata, 32'h7777_0007);
        step();
        do_reset("reset2");

        // Counter saturation on r2.
        issue_valid = 1; issue_wb = 1; issue_rd = 2;
        for (int k = 0; k < 3; k++) step();
        #1; check_eq("sat_stall_4th", stall_OF, 1);
        step();
        step();
        #1; check_eq("sat_busy2", busy[2], 1);
        idle();

        // Same-cycle inc and dec on r4 at cnt=1.
        issue_valid = 1; issue_wb = 1; issue_rd = 4;
        step();
        idle();
        wb_valid = 1; wb_rd = 4; wb_data = 32'h0000_0044;
        step();
        idle();
        issue_valid = 1; issue_wb = 1; issue_rd = 4;
        #1; check_eq("same_reg_we", rf_we, 1);
        step();
        idle();
        #1; check_eq("same_reg_busy4", busy[4], 1);
        step();

        // Underflow on r9 is sticky; reset mid-stream clears everything.
        wb_valid = 1; wb_rd = 9; wb_data = 32'h0000_0099;
        step();
        idle();
        step();
        #1; check_eq("uf_set", err_underflow, 1);
        for (int k = 0; k < 3; k++) step();
        #1; check_eq("uf_sticky", err_underflow, 1);
        issue_valid = 1; issue_use1 = 1; issue_rs1 = 2;
        do_reset("reset_mid");
        idle();

        // Randomized traffic with MDU requests held until accepted.
        for (int n = 0; n < 3000; n++) begin
            bit accepted;
            issue_valid = ($urandom_range(0, 1) == 1);
            issue_wb    = ($urandom_range(0, 2) != 0);
            issue_use1  = ($urandom_range(0, 1) == 1);
            issue_use2  = ($urandom_range(0, 1) == 1);
            issue_rd    = 4'($urandom_range(0, 7));
            issue_rs1   = 4'($urandom_range(0, 7));
            issue_rs2   = 4'($urandom_range(0, 7));
            wb_valid    = ($urandom_range(0, 3) == 0);
            wb_rd       = 4'($urandom_range(0, 7));
            wb_data     = $urandom;
            if (!mdu_valid && $urandom_range(0, 3) == 0) begin
                mdu_valid = 1;
                mdu_rd    = 4'($urandom_range(0, 7));
                mdu_data  = $urandom;
            end
            if ($urandom_range(0, 299) == 0) begin
                do_reset("rand_reset");
            end
            accepted = mdu_valid && !wb_valid;
            step();
            if (accepted) mdu_valid = 0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
